// File: rtl/fft4_frame_sched.sv
// Frame scheduler for the combinational four-point FFT core: collects 4-sample frames,
// launches them into the core, captures results and streams the four bins out.
// Optional feature: FFT_SCHED_PINGPONG_EN lets sample collection overlap compute/drain.
module fft4_frame_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic [3:0] fa,
    output logic [3:0] fb,
    output logic [3:0] fc,
    output logic [3:0] fd,
    input  logic [5:0] fA,
    input  logic [5:0] fAi,
    input  logic [5:0] fB,
    input  logic [5:0] fBi,
    input  logic [5:0] fC,
    input  logic [5:0] fCi,
    input  logic [5:0] fD,
    input  logic [5:0] fDi,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_re,
    output logic [5:0] out_im,
    output logic [1:0] out_idx,
    output logic       out_last,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned SW = 4;
    localparam int unsigned RW = 6;
    localparam int unsigned NS = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned IW = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [IW-1:0] idx, idx_d, idx_nx;
    logic [SW-1:0] sbuf    [NS];
    logic [SW-1:0] sbuf_d  [NS];
    logic [RW-1:0] bank_re [NS];
    logic [RW-1:0] bank_im [NS];
    logic [RW-1:0] bank_re_d [NS];
    logic [RW-1:0] bank_im_d [NS];

    logic [SW-1:0] fa_d, fb_d, fc_d, fd_d;
    logic          out_valid_d, out_last_d, busy_d, frame_done_d;
    logic [RW-1:0] out_re_d, out_im_d;
    logic [IW-1:0] out_idx_d;
    logic          in_hs, out_hs;

    // Ping-pong: the sample buffer is decoupled from the operands, so only fullness gates input.
`ifdef FFT_SCHED_PINGPONG_EN
    assign in_ready = (cnt < CW'(NS));
`else
    assign in_ready = (cnt < CW'(NS)) && (state == IDLE);
`endif

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;
    assign idx_nx = idx + IW'(1);

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        idx_d        = idx;
        sbuf_d       = sbuf;
        bank_re_d    = bank_re;
        bank_im_d    = bank_im;
        fa_d         = fa;
        fb_d         = fb;
        fc_d         = fc;
        fd_d         = fd;
        out_valid_d  = out_valid;
        out_re_d     = out_re;
        out_im_d     = out_im;
        out_idx_d    = out_idx;
        out_last_d   = out_last;
        frame_done_d = 1'b0;

        if (in_hs) begin
            sbuf_d[cnt[IW-1:0]] = in_data;
            cnt_d               = cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                if (cnt == CW'(NS)) begin
                    fa_d    = sbuf[0];
                    fb_d    = sbuf[1];
                    fc_d    = sbuf[2];
                    fd_d    = sbuf[3];
                    cnt_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                // Core has had one full cycle to settle on fa..fd
                bank_re_d[0] = fA;
                bank_im_d[0] = fAi;
                bank_re_d[1] = fB;
                bank_im_d[1] = fBi;
                bank_re_d[2] = fC;
                bank_im_d[2] = fCi;
                bank_re_d[3] = fD;
                bank_im_d[3] = fDi;
                idx_d        = '0;
                out_valid_d  = 1'b1;
                out_re_d     = fA;
                out_im_d     = fAi;
                out_idx_d    = '0;
                out_last_d   = 1'b0;
                state_d      = DRAIN;
            end
            DRAIN: begin
                if (out_hs) begin
                    if (idx == IW'(NS - 1)) begin
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        idx_d      = idx_nx;
                        out_re_d   = bank_re[idx_nx];
                        out_im_d   = bank_im[idx_nx];
                        out_idx_d  = idx_nx;
                        out_last_d = (idx_nx == IW'(NS - 1));
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            for (int i = 0; i < NS; i++) begin
                sbuf[i]    <= '0;
                bank_re[i] <= '0;
                bank_im[i] <= '0;
            end
            fa         <= '0;
            fb         <= '0;
            fc         <= '0;
            fd         <= '0;
            out_valid  <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            for (int i = 0; i < NS; i++) begin
                sbuf[i]    <= sbuf_d[i];
                bank_re[i] <= bank_re_d[i];
                bank_im[i] <= bank_im_d[i];
            end
            fa         <= fa_d;
            fb         <= fb_d;
            fc         <= fc_d;
            fd         <= fd_d;
            out_valid  <= out_valid_d;
            out_re     <= out_re_d;
            out_im     <= out_im_d;
            out_idx    <= out_idx_d;
            out_last   <= out_last_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_fft4_frame_sched.sv
// Self-checking bench for fft4_frame_sched: a queue-based frame model plus a behavioural
// stand-in for the four-point FFT core; honours FFT_SCHED_PINGPONG_EN like the design.
module tb_fft4_frame_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [3:0] in_data;
    logic [3:0] fa, fb, fc, fd;
    logic [5:0] fA, fAi, fB, fBi, fC, fCi, fD, fDi;
    logic       out_valid, out_ready;
    logic [5:0] out_re, out_im;
    logic [1:0] out_idx;
    logic       out_last, busy, frame_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fft4_frame_sched dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .fa(fa), .fb(fb), .fc(fc), .fd(fd),
        .fA(fA), .fAi(fAi), .fB(fB), .fBi(fBi),
        .fC(fC), .fCi(fCi), .fD(fD), .fDi(fDi),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .frame_done(frame_done)
    );

    // Four-point DIT FFT of unsigned samples, wrapped to 6 bits: {A,Ai,B,Bi,C,Ci,D,Di}
    function automatic logic [47:0] fcore(input logic [3:0] a, b, c, d);
        logic [5:0] xa, xb, xc, xd;
        xa = 6'(a);
        xb = 6'(b);
        xc = 6'(c);
        xd = 6'(d);
        return {xa + xb + xc + xd, 6'd0, xa - xc, xd - xb,
                xa - xb + xc - xd, 6'd0, xa - xc, xb - xd};
    endfunction

    logic [47:0] core_o;
    assign core_o = fcore(fa, fb, fc, fd);
    assign {fA, fAi, fB, fBi, fC, fCi, fD, fDi} = core_o;

    // Model: pending samples, operands in flight, and bins still owed downstream
    logic [3:0] m_samp[$];
    logic [3:0] m_ops[4];
    logic [5:0] m_re[$];
    logic [5:0] m_im[$];
    bit         m_comp;
    bit         m_fd;
    bit         m_hs_in, m_hs_out, m_idle;
    logic [47:0] m_res;

    function automatic bit exp_in_ready();
`ifdef FFT_SCHED_PINGPONG_EN
        return m_samp.size() < 4;
`else
        return (m_samp.size() < 4) && !m_comp && (m_re.size() == 0);
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_samp.delete();
            m_re.delete();
            m_im.delete();
            for (int i = 0; i < 4; i++) m_ops[i] = 4'h0;
            m_comp = 1'b0;
            m_fd   = 1'b0;
        end else begin
            m_idle   = !m_comp && (m_re.size() == 0);
            m_hs_in  = in_valid && exp_in_ready();
            m_hs_out = (m_re.size() > 0) && out_ready;
            m_fd     = 1'b0;
            if (m_comp) begin
                m_res = fcore(m_ops[0], m_ops[1], m_ops[2], m_ops[3]);
                for (int k = 0; k < 4; k++) begin
                    m_re.push_back(m_res[47 - 12*k -: 6]);
                    m_im.push_back(m_res[41 - 12*k -: 6]);
                end
                m_comp = 1'b0;
            end else if (m_hs_out) begin
                void'(m_re.pop_front());
                void'(m_im.pop_front());
                if (m_re.size() == 0) m_fd = 1'b1;
            end else if (m_idle && m_samp.size() == 4) begin
                for (int i = 0; i < 4; i++) m_ops[i] = m_samp.pop_front();
                m_comp = 1'b1;
            end
            if (m_hs_in) m_samp.push_back(in_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(exp_in_ready()));
            chk("out_valid", 32'(out_valid), 32'(m_re.size() > 0));
            chk("busy", 32'(busy), 32'(m_comp || (m_re.size() > 0)));
            chk("frame_done", 32'(frame_done), 32'(m_fd));
            chk("fa", 32'(fa), 32'(m_ops[0]));
            chk("fb", 32'(fb), 32'(m_ops[1]));
            chk("fc", 32'(fc), 32'(m_ops[2]));
            chk("fd", 32'(fd), 32'(m_ops[3]));
            if (m_re.size() > 0) begin
                chk("out_re", 32'(out_re), 32'(m_re[0]));
                chk("out_im", 32'(out_im), 32'(m_im[0]));
                chk("out_idx", 32'(out_idx), 32'(4 - m_re.size()));
                chk("out_last", 32'(out_last), 32'(m_re.size() == 1));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic send_frame(input logic [3:0] a, b, c, d);
        in_valid = 1'b1;
        in_data = a; step();
        in_data = b; step();
        in_data = c; step();
        in_data = d; step();
        in_valid = 1'b0;
    endtask

    task automatic wait_frame_done(input string name);
        int n = 0;
        while (!frame_done && n < 40) begin
            step();
            n++;
        end
        chk(name, 32'(frame_done), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fa", 32'({fa, fb, fc, fd}), 32'h0);
        chk("rst_out", 32'({out_re, out_im, out_idx, out_last}), 32'h0);

        // Frame 1,2,3,4 with out_ready high: fixed latency profile
        out_ready = 1'b1;
        send_frame(4'd1, 4'd2, 4'd3, 4'd4);
        step();
        chk("lat_ops", 32'({fa, fb, fc, fd}), 32'h1234);
        chk("lat_nvalid", 32'(out_valid), 32'd0);
        step();
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("bin0_re", 32'(out_re), 32'h0A);
        chk("bin0_idx", 32'(out_idx), 32'd0);
        step();
        chk("bin1_im", 32'(out_im), 32'h02);
        step();
        chk("bin2_re", 32'(out_re), 32'h3E);
        step();
        chk("bin3_last", 32'({out_idx, out_last}), 32'h7);
        chk("bin3_im", 32'(out_im), 32'h3E);
        step();
        chk("done_pulse", 32'(frame_done), 32'd1);
        chk("done_nvalid", 32'(out_valid), 32'd0);
        step();
        chk("done_once", 32'(frame_done), 32'd0);

        // Backpressure at bin 1
        do_reset();
        send_frame(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        begin
            int n = 0;
            while (!out_valid && n < 10) begin step(); n++; end
            chk("bp_wait", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (5) begin
            step();
            chk("bp_idx", 32'(out_idx), 32'd1);
            chk("bp_nodone", 32'(frame_done), 32'd0);
        end
        out_ready = 1'b1;
        wait_frame_done("bp_done");

        // Back-to-back frames with in_valid held high
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_data = 4'($urandom);
            step();
            if (i == 4) begin
`ifdef FFT_SCHED_PINGPONG_EN
                chk("tp_ready_compute", 32'(in_ready), 32'd1);
`else
                chk("tp_ready_compute", 32'(in_ready), 32'd0);
`endif
            end
        end
        in_valid = 1'b0;
        repeat (14) step();

        // Gapped input of all-15 samples
        do_reset();
        out_ready = 1'b1;
        in_data = 4'hF;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            step();
            if (i == 6) chk("gap_nolaunch", 32'(busy), 32'd0);
        end
        in_valid = 1'b0;
        chk("gap_ops", 32'({fa, fb, fc, fd}), 32'hFFFF);
        chk("gap_busy", 32'(busy), 32'd1);
        wait_frame_done("gap_done");

        // Asynchronous reset in the middle of draining
        do_reset();
        out_ready = 1'b1;
        send_frame(4'd9, 4'd8, 4'd7, 4'd6);
        begin
            int n = 0;
            while (!(out_valid && out_idx == 2'd2) && n < 12) begin step(); n++; end
            chk("ar_reach_idx2", 32'(out_idx), 32'd2);
        end
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_ops", 32'({fa, fb, fc, fd}), 32'h0);
        chk("ar_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("ar_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send_frame(4'd5, 4'd6, 4'd7, 4'd8);
        step();
        chk("ar_next_ops", 32'({fa, fb, fc, fd}), 32'h5678);
        wait_frame_done("ar_next_done");

        // Randomized traffic with random gaps and stalls
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0) && !((i / 200) % 3 == 2 && (i % 200) < 15);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (30) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
